// File: rtl/lsu_mem_master_pkg.sv
// Shared constants, FSM encoding and funct3 decode helpers for the LSU RAM initiator.
package lsu_mem_master_pkg;

  localparam logic [1:0] STORE_B  = 2'b00;
  localparam logic [1:0] STORE_HW = 2'b01;
  localparam logic [1:0] STORE_W  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD0  = 3'd2,
    S_RD1  = 3'd3,
    S_RD2  = 3'd4,
    S_DONE = 3'd5
  } lsu_state_e;

  function automatic logic ld_f3_legal(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic st_f3_legal(input logic [2:0] f3);
    return f3 < 3'b011;
  endfunction

  // True when the load spans two RAM words and needs a second read.
  function automatic logic ld_crosses(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LH, F3_LHU: return off == 2'd3;
      F3_LW:         return off != 2'd0;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] st_ctrl(input logic [2:0] f3);
    case (f3)
      F3_SB:   return STORE_B;
      F3_SH:   return STORE_HW;
      default: return STORE_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_load_align.sv
// Shifts the {hi,lo} word pair by the byte offset and sign/zero extends per load type.
module lsu_load_align
  import lsu_mem_master_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o
);

  logic [63:0] shifted_s;

  always_comb begin
    shifted_s = data_i >> {off_i, 3'b000};
    case (funct3_i)
      F3_LB:   rdata_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_LBU:  rdata_o = {24'h000000, shifted_s[7:0]};
      F3_LH:   rdata_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_LHU:  rdata_o = {16'h0000, shifted_s[15:0]};
      F3_LW:   rdata_o = shifted_s[31:0];
      default: rdata_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator for a RAM with one-cycle registered read latency.
module lsu_mem_master
  import lsu_mem_master_pkg::*;
#(
  parameter bit SPLIT_LD = 1'b1
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [1:0]  mem_ctrl,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] lo_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_we_q;
  logic [1:0]  mem_ctrl_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        st_bad_s;
  logic        ld_bad_s;
  logic [31:0] word_s;
  logic [63:0] ld_pair_s;
  logic [31:0] ld_data_s;

  // Accept-time legality decode and the word pair fed to the aligner.
  always_comb begin
    st_bad_s = !st_f3_legal(req_funct3)
             || (req_funct3 == F3_SH && req_addr[1:0] == 2'd3)
             || (req_funct3 == F3_SW && req_addr[1:0] != 2'd0);
    ld_bad_s = !ld_f3_legal(req_funct3)
             || (ld_crosses(req_funct3, req_addr[1:0]) && !SPLIT_LD);
    word_s   = {addr_q[31:2], 2'b00};
    if (state_q == S_RD2) begin
      ld_pair_s = {mem_rdata, lo_q};
    end else begin
      ld_pair_s = {32'h0000_0000, mem_rdata};
    end
  end

  lsu_load_align u_align (
    .data_i   (ld_pair_s),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .rdata_o  (ld_data_s)
  );

  // Request FSM; every core- and RAM-facing output is loaded on the transition into its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      f3_q         <= 3'b000;
      addr_q       <= 32'h0000_0000;
      lo_q         <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      mem_we_q     <= 1'b0;
      mem_ctrl_q   <= STORE_W;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            f3_q   <= req_funct3;
            addr_q <= req_addr;
            if ((req_we && st_bad_s) || (!req_we && ld_bad_s)) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0000_0000;
            end else if (req_we) begin
              state_q     <= S_WR;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= req_addr;
              mem_ctrl_q  <= st_ctrl(req_funct3);
              mem_wdata_q <= req_wdata;
            end else begin
              state_q    <= S_RD0;
              mem_addr_q <= {req_addr[31:2], 2'b00};
            end
          end
        end
        S_WR: begin
          state_q      <= S_DONE;
          mem_we_q     <= 1'b0;
          mem_ctrl_q   <= STORE_W;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0000_0000;
        end
        S_RD0: begin
          state_q    <= S_RD1;
          mem_addr_q <= word_s + 32'd4;
        end
        S_RD1: begin
          lo_q <= mem_rdata;
          if (ld_crosses(f3_q, addr_q[1:0])) begin
            state_q <= S_RD2;
          end else begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= ld_data_s;
          end
        end
        S_RD2: begin
          state_q      <= S_DONE;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= ld_data_s;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_we     = mem_we_q;
  assign mem_ctrl   = mem_ctrl_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master against a byte-addressed RAM with registered reads.
module tb_lsu_mem_master;
  import lsu_mem_master_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [1:0]  mem_ctrl;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        r0_valid, r0_ready, r0_we;
  logic [2:0]  r0_funct3;
  logic [31:0] r0_addr;
  logic        r0_resp_valid, r0_resp_err, r0_mem_we;
  logic [31:0] r0_resp_rdata, r0_mem_addr, r0_mem_wdata;
  logic [1:0]  r0_mem_ctrl;

  lsu_mem_master #(.SPLIT_LD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  lsu_mem_master #(.SPLIT_LD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r0_valid), .req_ready(r0_ready), .req_we(r0_we),
    .req_funct3(r0_funct3), .req_addr(r0_addr), .req_wdata(32'h0000_0000),
    .resp_valid(r0_resp_valid), .resp_rdata(r0_resp_rdata), .resp_err(r0_resp_err),
    .mem_we(r0_mem_we), .mem_ctrl(r0_mem_ctrl), .mem_addr(r0_mem_addr),
    .mem_wdata(r0_mem_wdata), .mem_rdata(32'h0000_0000)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q1[$];
  exp_t        q0[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  logic [31:0] last_we_addr, last_we_data;
  logic [1:0]  last_we_ctrl;
  logic [31:0] prev_addr = 32'h0000_0000;
  logic [31:0] addr_log[$];
  logic [7:0]  ram [0:63];
  logic        preload_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: little-endian bytes, unshifted write data, registered word read.
  always @(posedge clk) begin
    if (!preload_done) begin
      for (int i = 0; i < 64; i++) ram[i] <= 8'h00;
      ram[16] <= 8'hBB; ram[17] <= 8'hAA; ram[18] <= 8'h99; ram[19] <= 8'h88;
      ram[20] <= 8'h44; ram[21] <= 8'h33; ram[22] <= 8'h22; ram[23] <= 8'h11;
      preload_done <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr[5:0]] <= mem_wdata[7:0];
      if (mem_ctrl != STORE_B) ram[mem_addr[5:0] + 6'd1] <= mem_wdata[15:8];
      if (mem_ctrl == STORE_W) begin
        ram[mem_addr[5:0] + 6'd2] <= mem_wdata[23:16];
        ram[mem_addr[5:0] + 6'd3] <= mem_wdata[31:24];
      end
    end
    mem_rdata <= {ram[{mem_addr[5:2], 2'b11}], ram[{mem_addr[5:2], 2'b10}],
                  ram[{mem_addr[5:2], 2'b01}], ram[{mem_addr[5:2], 2'b00}]};
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor for the split-enabled DUT: pops the scoreboard on every response.
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= mem_addr;
      last_we_ctrl <= mem_ctrl;
      last_we_data <= mem_wdata;
    end
    prev_addr <= mem_addr;
    if (mem_addr != prev_addr) addr_log.push_back(mem_addr);
    if (rst_n && resp_valid) begin
      if (q1.size() == 0) begin
        check32("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check32("rdata", resp_rdata, e.rdata);
        check32("err", 32'(resp_err), 32'(e.err));
        check32("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  // Monitor for the split-disabled DUT.
  always @(negedge clk) begin
    if (rst_n && r0_resp_valid) begin
      if (q0.size() == 0) begin
        check32("unexpected_resp0", 32'(r0_resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check32("rdata0", r0_resp_rdata, e.rdata);
        check32("err0", 32'(r0_resp_err), 32'(e.err));
        check32("latency0", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input logic push, input logic drop, output int acc);
    int n = 0;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!req_ready) begin
      check32("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      if (push) q1.push_back('{rdata: exp_rd, err: exp_err, lat: lat, acc: cyc});
      if (drop) req_valid = 1'b0;
    end
  endtask

  task automatic issue0(input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat);
    r0_we = 1'b0; r0_funct3 = f3; r0_addr = addr; r0_valid = 1'b1;
    @(negedge clk);
    check32("ready0", 32'(r0_ready), 32'd1);
    @(posedge clk);
    #1;
    q0.push_back('{rdata: exp_rd, err: exp_err, lat: lat, acc: cyc});
    r0_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check32("drain0", 32'(q0.size()), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q1.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check32("drain", 32'(q1.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int a0, a1, a2, base, wbase;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    r0_valid = 1'b0; r0_we = 1'b0; r0_funct3 = 3'b000; r0_addr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check32("rst_ready", 32'(req_ready), 32'd1);
    check32("rst_resp_valid", 32'(resp_valid), 32'd0);
    check32("rst_mem_ctrl", 32'(mem_ctrl), 32'(STORE_W));
    check32("rst_mem_addr", mem_addr, 32'h0);

    issue(1'b0, F3_LB,  32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0, 3, 1'b1, 1'b1, a0);
    issue(1'b0, F3_LBU, 32'h11, 32'h0, 32'h0000_00AA, 1'b0, 3, 1'b1, 1'b1, a0);
    issue(1'b0, F3_LH,  32'h13, 32'h0, 32'h0000_4488, 1'b0, 4, 1'b1, 1'b1, a0);
    issue(1'b0, F3_LHU, 32'h12, 32'h0, 32'h0000_8899, 1'b0, 3, 1'b1, 1'b1, a0);
    issue(1'b0, F3_LH,  32'h12, 32'h0, 32'hFFFF_8899, 1'b0, 3, 1'b1, 1'b1, a0);
    wait_idle();

    base = addr_log.size();
    issue(1'b0, F3_LW, 32'h13, 32'h0, 32'h2233_4488, 1'b0, 4, 1'b1, 1'b1, a0);
    wait_idle();
    check32("split_nreads", 32'(addr_log.size() - base), 32'd2);
    if (addr_log.size() >= base + 2) begin
      check32("split_addr0", addr_log[base], 32'h10);
      check32("split_addr1", addr_log[base + 1], 32'h14);
    end

    issue0(F3_LW, 32'h13, 32'h0, 1'b1, 1);
    issue0(F3_LH, 32'h13, 32'h0, 1'b1, 1);
    issue0(F3_LW, 32'h10, 32'h0, 1'b0, 3);

    wbase = we_cnt;
    issue(1'b1, F3_SH, 32'h12, 32'h1234_BEEF, 32'h0, 1'b0, 2, 1'b1, 1'b1, a0);
    wait_idle();
    check32("sh_we_pulses", 32'(we_cnt - wbase), 32'd1);
    check32("sh_addr", last_we_addr, 32'h12);
    check32("sh_ctrl", 32'(last_we_ctrl), 32'(STORE_HW));
    check32("sh_wdata", last_we_data, 32'h1234_BEEF);
    issue(1'b0, F3_LW, 32'h10, 32'h0, 32'hBEEF_AABB, 1'b0, 3, 1'b1, 1'b1, a0);

    wbase = we_cnt;
    issue(1'b1, F3_SW, 32'h16, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 1'b1, 1'b1, a0);
    issue(1'b1, F3_SH, 32'h13, 32'hDEAD_BEEF, 32'h0, 1'b1, 1, 1'b1, 1'b1, a0);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b1, 1'b1, a0);
    wait_idle();
    check32("err_no_we", 32'(we_cnt - wbase), 32'd0);

    issue(1'b0, F3_LW, 32'h14, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b1, a0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check32("arst_resp_valid", 32'(resp_valid), 32'd0);
    check32("arst_resp_err", 32'(resp_err), 32'd0);
    check32("arst_resp_rdata", resp_rdata, 32'h0);
    check32("arst_mem_we", 32'(mem_we), 32'd0);
    check32("arst_mem_addr", mem_addr, 32'h0);
    check32("arst_mem_wdata", mem_wdata, 32'h0);
    check32("arst_mem_ctrl", 32'(mem_ctrl), 32'(STORE_W));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    issue(1'b0, F3_LW, 32'h14, 32'h0, 32'h1122_3344, 1'b0, 3, 1'b1, 1'b1, a0);
    wait_idle();

    issue(1'b0, F3_LW,  32'h10, 32'h0, 32'hBEEF_AABB, 1'b0, 3, 1'b1, 1'b0, a0);
    check32("busy_ready", 32'(req_ready), 32'd0);
    issue(1'b0, F3_LBU, 32'h16, 32'h0, 32'h0000_0022, 1'b0, 3, 1'b1, 1'b0, a1);
    issue(1'b0, F3_LH,  32'h14, 32'h0, 32'h0000_3344, 1'b0, 3, 1'b1, 1'b1, a2);
    check32("b2b_gap01", 32'(a1 - a0), 32'd4);
    check32("b2b_gap12", 32'(a2 - a1), 32'd4);
    wait_idle();

    issue(1'b1, F3_SB, 32'h17, 32'h0000_00FF, 32'h0, 1'b0, 2, 1'b1, 1'b1, a0);
    issue(1'b0, F3_LB, 32'h17, 32'h0, 32'hFFFF_FFFF, 1'b0, 3, 1'b1, 1'b1, a0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
